// File: rtl/serv_bufreg_pkg.sv
// Shared encodings for the serial buffer-register sequencer: operation codes,
// controller states and the last bit index of a 32-bit word.
package serv_bufreg_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_SHIFT = 2'b10;
   localparam logic [1:0] OP_MDU   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_BUS  = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   localparam logic [4:0] CNT_LAST = 5'd31;

endpackage

// File: rtl/serv_bufreg_ctrl_bit_cnt.sv
// 5-bit serial bit counter with enable and synchronous clear; decodes the
// first, second and last bit positions of a word.
module serv_bit_cnt
   import serv_bufreg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic cnt0,
   output logic cnt1,
   output logic cnt_done
);

   logic [4:0] cnt;

   // Wraps 31 -> 0 on its own, so consecutive 32-cycle phases need no clear.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= 5'd0;
      end else if (en) begin
         cnt <= cnt + 5'd1;
      end
   end

   assign cnt0     = (cnt == 5'd0);
   assign cnt1     = (cnt == 5'd1);
   assign cnt_done = (cnt == CNT_LAST);

endmodule

// File: rtl/serv_bufreg_ctrl.sv
// Sequencer for the bit-serial buffer register: INIT phase, then bus handshake
// or RUN phase. Optional bus watchdog enabled by SERV_BUFREG_CTRL_TIMEOUT_EN.
module serv_bufreg_ctrl
   import serv_bufreg_pkg::*;
#(
   parameter int          MDU     = 0,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_req,
   input  logic [1:0] i_op,
   output logic       o_ready,
   output logic       o_en,
   output logic       o_init,
   output logic       o_cnt0,
   output logic       o_cnt1,
   output logic       o_cnt_done,
   output logic       o_mdu_op,
   output logic       o_dbus_cyc,
   output logic       o_dbus_we,
   input  logic       i_dbus_ack,
   output logic       o_done,
   output logic       o_err
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] op_q;
   logic       mdu_q;
   logic       done_q;
   logic       err_q;

   logic accept;
   logic cnt_en;
   logic cnt0_raw;
   logic cnt1_raw;
   logic cnt_done_raw;
   logic bus_ack;
   logic run_end;
   logic bus_timeout;
   logic is_mem_op;

   assign accept    = (state == S_IDLE) && i_req;
   assign cnt_en    = (state == S_INIT) || (state == S_RUN);
   assign bus_ack   = (state == S_BUS) && i_dbus_ack;
   assign run_end   = (state == S_RUN) && cnt_done_raw;
   assign is_mem_op = (op_q == OP_LOAD) || (op_q == OP_STORE);

   serv_bit_cnt u_bit_cnt (
      .clk      (i_clk),
      .rst      (i_rst),
      .en       (cnt_en),
      .clr      (accept),
      .cnt0     (cnt0_raw),
      .cnt1     (cnt1_raw),
      .cnt_done (cnt_done_raw)
   );

`ifdef SERV_BUFREG_CTRL_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wd;

   // Counts completed BUS cycles; held at zero whenever the bus is idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wd <= 8'd0;
      end else if (state == S_BUS) begin
         wd <= wd + 8'd1;
      end else begin
         wd <= 8'd0;
      end
   end

   // An ack in the limit cycle takes priority over the timeout.
   assign bus_timeout = (state == S_BUS) && !i_dbus_ack && (wd == WD_LAST);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign bus_timeout    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (i_req)                      state_nxt = S_INIT;
         S_INIT: if (cnt_done_raw)               state_nxt = is_mem_op ? S_BUS : S_RUN;
         S_BUS:  if (i_dbus_ack || bus_timeout)  state_nxt = S_IDLE;
         S_RUN:  if (cnt_done_raw)               state_nxt = S_IDLE;
         default:                                state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= S_IDLE;
         op_q   <= OP_LOAD;
         mdu_q  <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= bus_ack || run_end;
         err_q  <= bus_timeout;
         if (accept) begin
            op_q  <= i_op;
            mdu_q <= (MDU != 0) && (i_op == OP_MDU);
         end
      end
   end

   assign o_ready    = (state == S_IDLE);
   assign o_en       = cnt_en;
   assign o_init     = (state == S_INIT);
   assign o_cnt0     = cnt_en && cnt0_raw;
   assign o_cnt1     = cnt_en && cnt1_raw;
   assign o_cnt_done = cnt_en && cnt_done_raw;
   assign o_mdu_op   = mdu_q;
   assign o_dbus_cyc = (state == S_BUS);
   assign o_dbus_we  = (state == S_BUS) && (op_q == OP_STORE);
   assign o_done     = done_q;
   assign o_err      = err_q;

endmodule

// File: tb/tb_serv_bufreg_ctrl.sv
// Bench for serv_bufreg_ctrl: MDU=1 and MDU=0 instances share stimulus; the
// watchdog vector is included only when SERV_BUFREG_CTRL_TIMEOUT_EN is defined.
module tb_serv_bufreg_ctrl;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [1:0] op;
   logic       ack;

   logic ready1, en1, init1, c01, c11, cd1, mdu1, dcyc1, we1, done1, err1;
   logic ready0, en0, init0, c00, c10, cd0, mdu0, dcyc0, we0, done0, err0;

   wire [10:0] v1 = {ready1, en1, init1, c01, c11, cd1, mdu1, dcyc1, we1, done1, err1};
   wire [10:0] v0 = {ready0, en0, init0, c00, c10, cd0, mdu0, dcyc0, we0, done0, err0};

   serv_bufreg_ctrl #(.MDU(1), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op),
      .o_ready(ready1), .o_en(en1), .o_init(init1), .o_cnt0(c01), .o_cnt1(c11),
      .o_cnt_done(cd1), .o_mdu_op(mdu1), .o_dbus_cyc(dcyc1), .o_dbus_we(we1),
      .i_dbus_ack(ack), .o_done(done1), .o_err(err1)
   );

   serv_bufreg_ctrl #(.MDU(0), .TIMEOUT(TO)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op),
      .o_ready(ready0), .o_en(en0), .o_init(init0), .o_cnt0(c00), .o_cnt1(c10),
      .o_cnt_done(cd0), .o_mdu_op(mdu0), .o_dbus_cyc(dcyc0), .o_dbus_we(we0),
      .i_dbus_ack(ack), .o_done(done0), .o_err(err0)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] exp_q[$];
   logic        last_mdu = 1'b0;

   typedef struct {
      logic [1:0] op;
      int         w;
      bit         ack_early;
      bit         hold_req;
      bit         b2b;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // scoreboard: every o_done pops the expected completion cycle
   always @(negedge clk) begin
      if (done1 === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL done_sb: unexpected o_done at cycle %0d", cyc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (e != 32'(cyc)) begin
               n_err++;
               $display("FAIL done_sb: o_done at cycle %0d expected %0d", cyc, e);
            end
         end
      end
   end

   task automatic idle(input int n);
      logic [10:0] e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req = 1'b0;
         ack = 1'b0;
         @(negedge clk);
         e = 11'b100_0000_0000;
         e[4] = last_mdu;
         chk("idle_dut1", v1, e);
         chk("idle_dut0", v0, 11'b100_0000_0000);
      end
   endtask

   // Called while the controller is idle; returns after checking the done cycle.
   task automatic run_op(input logic [1:0] o, input int w, input bit ack_early, input bit hold_req);
      bit          is_bus;
      bit          to;
      int          bus_end;
      int          last;
      logic [10:0] e;
      is_bus  = (o == 2'b00) || (o == 2'b01);
      to      = is_bus && (w < 0);
      bus_end = to ? 33 + TO - 1 : 33 + w;
      last    = is_bus ? bus_end + 1 : 65;
      req = 1'b1;
      op  = o;
      ack = ack_early;
      if (!to) exp_q.push_back(32'(cyc + last));
      for (int k = 1; k <= last; k++) begin
         @(posedge clk); #1;
         req = hold_req && (k < last);
         op  = hold_req ? 2'($urandom_range(0, 3)) : o;
         ack = (is_bus && !to && k == bus_end) ||
               (ack_early && !to && k <= (is_bus ? bus_end : 64));
         @(negedge clk);
         e = '0;
         if (k <= 32) begin
            e[9] = 1'b1; e[8] = 1'b1;
            e[7] = (k == 1); e[6] = (k == 2); e[5] = (k == 32);
         end else if (k < last) begin
            if (is_bus) begin
               e[3] = 1'b1;
               e[2] = (o == 2'b01);
            end else begin
               e[9] = 1'b1;
               e[7] = (k == 33); e[6] = (k == 34); e[5] = (k == 64);
            end
         end else begin
            e[10] = 1'b1;
            e[1]  = !to;
            e[0]  = to;
         end
         chk($sformatf("op%0d_k%0d_dut0", o, k), v0, e);
         e[4] = (o == 2'b11);
         chk($sformatf("op%0d_k%0d_dut1", o, k), v1, e);
      end
      ack      = 1'b0;
      last_mdu = (o == 2'b11);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; req = 1'b0; op = 2'b00; ack = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk("reset_dut1", v1, 11'b100_0000_0000);
      chk("reset_dut0", v0, 11'b100_0000_0000);
      rst = 1'b0;
      for (int i = 0; i < 20 && cyc < 10; i++) idle(1);

      // op, ack wait, ack_early, hold_req, back-to-back
      vecs.push_back('{2'b00, 2, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{2'b01, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{2'b10, 0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{2'b10, 0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{2'b11, 0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{2'b11, 0, 1'b0, 1'b1, 1'b1});
      vecs.push_back('{2'b00, 5, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{2'b01, 1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{2'b00, TO - 1, 1'b0, 1'b0, 1'b0});
`ifdef SERV_BUFREG_CTRL_TIMEOUT_EN
      vecs.push_back('{2'b01, -1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{2'b00, -1, 1'b0, 1'b0, 1'b1});
`endif
      for (int i = 0; i < 4; i++) begin
         v.op        = 2'($urandom_range(0, 3));
         v.w         = int'($urandom_range(0, 5));
         v.ack_early = 1'b0;
         v.hold_req  = 1'($urandom_range(0, 1));
         v.b2b       = 1'($urandom_range(0, 1));
         vecs.push_back(v);
      end

      foreach (vecs[i]) begin
         if (!vecs[i].b2b) idle(2);
         run_op(vecs[i].op, vecs[i].w, vecs[i].ack_early, vecs[i].hold_req);
      end

      // reset at cnt=17 of INIT aborts silently and clears the latched op
      idle(1);
      req = 1'b1; op = 2'b11;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); #1;
         req = 1'b0;
      end
      rst = 1'b1; ack = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ack = 1'b0;
      @(negedge clk);
      chk("abort_dut1", v1, 11'b100_0000_0000);
      chk("abort_dut0", v0, 11'b100_0000_0000);
      last_mdu = 1'b0;
      run_op(2'b00, 1, 1'b0, 1'b0);

      idle(3);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL done_missing: %0d completions never seen, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
